// File: rtl/song_seq_pkg.sv
// Shared types and defaults for the song playback sequencer.
package song_seq_pkg;

    localparam int unsigned NOTE_W        = 4;
    localparam int unsigned NUM_SONGS_DEF = 4;
    localparam int unsigned SONG_W_DEF    = 2;
    localparam int unsigned PTR_W_DEF     = 8;

    localparam logic [NOTE_W-1:0] END_CODE_DEF  = 4'hF;
    localparam logic [NOTE_W-1:0] REST_CODE_DEF = 4'h0;

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LATCH = 3'd3,
        ST_PLAY  = 3'd4,
        ST_PAUSE = 3'd5
    } state_t;

endpackage

// File: rtl/song_sequencer.sv
// Note-ROM playback controller: play/pause, song select, end-of-song and looping.
// Advances on a one-cycle beat strobe; ROM data is sampled two cycles after the address.
module song_sequencer
    import song_seq_pkg::*;
#(
    parameter int unsigned       NUM_SONGS = NUM_SONGS_DEF,
    parameter int unsigned       SONG_W    = SONG_W_DEF,
    parameter int unsigned       PTR_W     = PTR_W_DEF,
    parameter logic [NOTE_W-1:0] END_CODE  = END_CODE_DEF,
    parameter logic [NOTE_W-1:0] REST_CODE = REST_CODE_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    beat_tick,
    input  logic                    btn_play,
    input  logic                    btn_next,
    input  logic                    btn_prev,
    input  logic                    loop_en,
    input  logic [NOTE_W-1:0]       rom_q,
    output logic [SONG_W+PTR_W-1:0] rom_addr,
    output logic [NOTE_W-1:0]       note,
    output logic                    mute,
    output logic                    playing,
    output logic [SONG_W-1:0]       song_idx,
    output logic                    song_done
);

    localparam int unsigned       ADDR_W   = SONG_W + PTR_W;
    localparam logic [PTR_W-1:0]  PTR_MAX  = '1;
    localparam logic [SONG_W-1:0] SONG_TOP = SONG_W'(NUM_SONGS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [SONG_W-1:0]   r_song,  w_song_next;
    logic [PTR_W-1:0]    r_ptr,   w_ptr_next;
    logic                r_tick_pend, w_tick_next;
    logic                r_pause_pend, w_pause_next;
    logic [NOTE_W-1:0]   r_note,  w_note_next;
    logic                r_mute,  w_mute_next;
    logic [ADDR_W-1:0]   r_addr,  w_addr_next;
    logic                r_playing, w_playing_next;
    logic                r_done,  w_done_next;

    logic w_sel;
    logic w_end;
    logic w_pause_req;

    assign w_sel       = btn_next | btn_prev;
    assign w_end       = (rom_q == END_CODE) || (r_ptr == PTR_MAX);
    assign w_pause_req = r_pause_pend | btn_play;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; song selection outranks every other input
    always_comb begin
        w_state_next = r_state;
        if (w_sel) begin
            if (r_state != ST_STOP) begin
                w_state_next = ST_FETCH;
            end
        end else begin
            case (r_state)
                ST_STOP:  if (btn_play) w_state_next = ST_FETCH;
                ST_FETCH: w_state_next = ST_WAIT;
                ST_WAIT:  w_state_next = ST_LATCH;
                ST_LATCH: begin
                    if (w_end) begin
                        w_state_next = loop_en ? ST_FETCH : ST_STOP;
                    end else begin
                        w_state_next = w_pause_req ? ST_PAUSE : ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (btn_play) begin
                        w_state_next = ST_PAUSE;
                    end else if (beat_tick || r_tick_pend) begin
                        w_state_next = ST_FETCH;
                    end
                end
                ST_PAUSE: if (btn_play) w_state_next = ST_PLAY;
                default:  w_state_next = ST_STOP;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        w_song_next  = r_song;
        w_ptr_next   = r_ptr;
        w_tick_next  = r_tick_pend;
        w_pause_next = r_pause_pend;
        w_note_next  = r_note;
        w_mute_next  = r_mute;
        w_done_next  = 1'b0;

        if (w_sel) begin
            if (btn_next) begin
                w_song_next = (r_song == SONG_TOP) ? '0 : r_song + SONG_W'(1);
            end else begin
                w_song_next = (r_song == '0) ? SONG_TOP : r_song - SONG_W'(1);
            end
            w_ptr_next = '0;
            if (r_state != ST_STOP) begin
                w_pause_next = 1'b0;
                w_tick_next  = beat_tick;
            end
        end else begin
            case (r_state)
                ST_STOP: begin
                    w_mute_next = 1'b1;
                    if (btn_play) begin
                        w_ptr_next  = '0;
                        w_tick_next = beat_tick;
                    end
                end
                ST_FETCH, ST_WAIT: begin
                    if (btn_play) begin
                        w_pause_next = 1'b1;
                    end else if (beat_tick) begin
                        w_tick_next = 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (btn_play) begin
                        w_pause_next = 1'b1;
                    end else if (beat_tick) begin
                        w_tick_next = 1'b1;
                    end
                    if (w_end) begin
                        if (loop_en) begin
                            w_ptr_next = '0;
                        end else begin
                            w_done_next  = 1'b1;
                            w_mute_next  = 1'b1;
                            w_tick_next  = 1'b0;
                            w_pause_next = 1'b0;
                        end
                    end else begin
                        w_note_next = rom_q;
                        if (w_pause_req) begin
                            w_mute_next  = 1'b1;
                            w_pause_next = 1'b0;
                            w_tick_next  = 1'b0;
                        end else begin
                            w_mute_next = (rom_q == REST_CODE);
                        end
                    end
                end
                ST_PLAY: begin
                    if (btn_play) begin
                        w_mute_next = 1'b1;
                        w_tick_next = 1'b0;
                    end else if (beat_tick || r_tick_pend) begin
                        w_ptr_next  = r_ptr + PTR_W'(1);
                        w_tick_next = 1'b0;
                    end
                end
                ST_PAUSE: begin
                    w_tick_next = 1'b0;
                    if (btn_play) begin
                        w_mute_next = (r_note == REST_CODE);
                    end
                end
                default: begin
                    w_mute_next = 1'b1;
                end
            endcase
        end

        w_addr_next    = (w_state_next == ST_FETCH) ? {w_song_next, w_ptr_next} : r_addr;
        w_playing_next = (w_state_next == ST_FETCH) || (w_state_next == ST_WAIT) ||
                         (w_state_next == ST_LATCH) || (w_state_next == ST_PLAY);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_song       <= '0;
            r_ptr        <= '0;
            r_tick_pend  <= 1'b0;
            r_pause_pend <= 1'b0;
            r_note       <= REST_CODE;
            r_mute       <= 1'b1;
            r_addr       <= '0;
            r_playing    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_song       <= w_song_next;
            r_ptr        <= w_ptr_next;
            r_tick_pend  <= w_tick_next;
            r_pause_pend <= w_pause_next;
            r_note       <= w_note_next;
            r_mute       <= w_mute_next;
            r_addr       <= w_addr_next;
            r_playing    <= w_playing_next;
            r_done       <= w_done_next;
        end
    end

    assign rom_addr  = r_addr;
    assign note      = r_note;
    assign mute      = r_mute;
    assign playing   = r_playing;
    assign song_idx  = r_song;
    assign song_done = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: a player model predicts every cycle's outputs,
// a negedge monitor compares them; directed scenarios plus a randomized run.
module tb_song_sequencer;

    logic       clk;
    logic       rst_n;
    logic       beat_tick, btn_play, btn_next, btn_prev, loop_en;
    logic [3:0] rom_q;
    logic [9:0] rom_addr;
    logic [3:0] note;
    logic       mute, playing, song_done;
    logic [1:0] song_idx;

    song_sequencer dut (
        .clk(clk), .rst_n(rst_n), .beat_tick(beat_tick), .btn_play(btn_play),
        .btn_next(btn_next), .btn_prev(btn_prev), .loop_en(loop_en), .rom_q(rom_q),
        .rom_addr(rom_addr), .note(note), .mute(mute), .playing(playing),
        .song_idx(song_idx), .song_done(song_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Note ROM with two cycles of read latency
    logic [3:0] mem [0:1023];
    logic [3:0] rom_q1;
    always @(posedge clk) begin
        rom_q1 <= mem[rom_addr];
        rom_q  <= rom_q1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d", name, got, exp);
    endtask

    // Player model: modes and a fetch age counter, ROM looked up directly
    localparam int M_STOP = 0, M_FETCH = 1, M_PLAY = 2, M_PAUSE = 3;
    int m_mode, m_age, m_song, m_ptr, m_note, m_addr;
    bit m_mute, m_tick, m_pause, m_done;

    typedef struct {
        int addr; int note; int mute; int playing; int song; int done_p;
    } exp_t;
    exp_t exp_q[$];

    task automatic model_reset();
        m_mode = M_STOP; m_age = 0; m_song = 0; m_ptr = 0; m_note = 0; m_addr = 0;
        m_mute = 1; m_tick = 0; m_pause = 0; m_done = 0;
    endtask

    task automatic start_fetch();
        m_mode = M_FETCH; m_age = 0; m_addr = m_song * 256 + m_ptr;
    endtask

    task automatic model_clock(input bit pl, input bit nx, input bit pv, input bit tk);
        int code;
        m_done = 0;
        if (nx || pv) begin
            m_song = nx ? (m_song + 1) % 4 : (m_song + 3) % 4;
            m_ptr  = 0;
            if (m_mode != M_STOP) begin
                m_pause = 0; m_tick = tk; start_fetch();
            end
        end else if (m_mode == M_STOP) begin
            if (pl) begin m_ptr = 0; m_tick = tk; start_fetch(); end
        end else if (m_mode == M_FETCH) begin
            if (pl) m_pause = 1; else if (tk) m_tick = 1;
            if (m_age < 2) m_age++;
            else begin
                code = int'(mem[m_song * 256 + m_ptr]);
                if (code == 15 || m_ptr == 255) begin
                    if (loop_en) begin m_ptr = 0; start_fetch(); end
                    else begin m_done = 1; m_mute = 1; m_mode = M_STOP; m_tick = 0; m_pause = 0; end
                end else begin
                    m_note = code;
                    if (m_pause) begin m_mode = M_PAUSE; m_mute = 1; m_pause = 0; m_tick = 0; end
                    else begin m_mode = M_PLAY; m_mute = (code == 0); end
                end
            end
        end else if (m_mode == M_PLAY) begin
            if (pl) begin m_mode = M_PAUSE; m_mute = 1; m_tick = 0; end
            else if (tk || m_tick) begin m_ptr++; m_tick = 0; start_fetch(); end
        end else begin
            m_tick = 0;
            if (pl) begin m_mode = M_PLAY; m_mute = (m_note == 0); end
        end
        exp_q.push_back('{m_addr, m_note, int'(m_mute),
                          int'(m_mode == M_FETCH || m_mode == M_PLAY), m_song, int'(m_done)});
    endtask

    // Monitor: compare every predicted cycle against the DUT
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (int'(rom_addr) == e.addr && int'(note) == e.note && int'(mute) == e.mute &&
                int'(playing) == e.playing && int'(song_idx) == e.song && int'(song_done) == e.done_p)
                n_pass++;
            else
                $display("FAIL cycle t=%0t got addr=%0h note=%0h mute=%0d play=%0d song=%0d done=%0d expected addr=%0h note=%0h mute=%0d play=%0d song=%0d done=%0d",
                         $time, rom_addr, note, mute, playing, song_idx, song_done,
                         e.addr, e.note, e.mute, e.playing, e.song, e.done_p);
        end
    end

    task automatic step(input bit pl, input bit nx, input bit pv, input bit tk);
        btn_play = pl; btn_next = nx; btn_prev = pv; beat_tick = tk;
        @(posedge clk); #1;
        model_clock(pl, nx, pv, tk);
        btn_play = 0; btn_next = 0; btn_prev = 0; beat_tick = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic chk_out(input string name, input int a, input int n, input int m, input int p);
        chk({name, "_addr"}, int'(rom_addr), a);
        chk({name, "_note"}, int'(note), n);
        chk({name, "_mute"}, int'(mute), m);
        chk({name, "_playing"}, int'(playing), p);
    endtask

    initial begin
        int len;
        bit pl, nx, pv, tk;
        rst_n = 0; beat_tick = 0; btn_play = 0; btn_next = 0; btn_prev = 0; loop_en = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 4'hF;
        mem[0] = 4'h3; mem[1] = 4'h5; mem[2] = 4'h0; mem[3] = 4'hF;
        mem[10'h100] = 4'h7; mem[10'h300] = 4'h9;
        model_reset();
        #12;
        chk_out("reset", 0, 0, 1, 0);
        chk("reset_song", int'(song_idx), 0);
        chk("reset_done", int'(song_done), 0);
        #10 rst_n = 1;

        // Plain playback to end of song
        step(1, 0, 0, 0); idle(3);
        chk_out("t1_n0", 0, 3, 0, 1);
        step(0, 0, 0, 1); idle(3);
        chk_out("t1_n1", 1, 5, 0, 1);
        step(0, 0, 0, 1); idle(3);
        chk_out("t1_n2", 2, 0, 1, 1);
        step(0, 0, 0, 1); idle(3);
        chk("t1_done", int'(song_done), 1);
        chk_out("t1_stop", 3, 0, 1, 0);
        idle(1);
        chk("t1_done_pulse", int'(song_done), 0);

        // Looping
        loop_en = 1;
        step(1, 0, 0, 0); idle(3);
        for (int k = 0; k < 3; k++) begin step(0, 0, 0, 1); idle(3); end
        chk("t2_loop_addr", int'(rom_addr), 0);
        chk("t2_loop_playing", int'(playing), 1);
        chk("t2_no_done", int'(song_done), 0);
        idle(3);
        chk_out("t2_n0", 0, 3, 0, 1);

        // Pause and resume on note 5
        step(0, 0, 0, 1); idle(3);
        step(1, 0, 0, 0);
        chk_out("t3_pause", 1, 5, 1, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 1);
        chk("t3_frozen", int'(rom_addr), 1);
        step(1, 0, 0, 0);
        chk_out("t3_resume", 1, 5, 0, 1);
        step(0, 0, 0, 1);
        chk("t3_advance", int'(rom_addr), 2);
        idle(3);

        // Song wrap both directions
        step(0, 0, 1, 0);
        chk("t4_prev_song", int'(song_idx), 3);
        chk("t4_prev_addr", int'(rom_addr), 10'h300);
        step(0, 1, 0, 0);
        chk("t4_next_song", int'(song_idx), 0);
        chk("t4_next_addr", int'(rom_addr), 0);
        idle(3);

        // Tick during WAIT is held; a second one is dropped
        step(0, 0, 0, 1); idle(1);
        step(0, 0, 0, 1); step(0, 0, 0, 1);
        idle(1);
        chk("t5_latched_note", int'(note), 5);
        idle(1);
        chk("t5_pend_advance", int'(rom_addr), 2);
        idle(5);
        chk("t5_single_advance", int'(rom_addr), 2);
        chk("t5_note", int'(note), 0);

        // Next beats play in the same cycle; then async reset mid-play
        step(1, 1, 0, 0);
        chk("t6_song", int'(song_idx), 1);
        chk_out("t6_fetch", 10'h100, 0, 1, 1);
        idle(3);
        chk_out("t6_play", 10'h100, 7, 0, 1);
        idle(2);
        @(negedge clk); #1;
        rst_n = 0; #1;
        chk_out("t6_areset", 0, 0, 1, 0);
        chk("t6_areset_song", int'(song_idx), 0);
        model_reset();
        @(posedge clk); #1 rst_n = 1;

        // Randomized content; song 3 has no end marker
        for (int s = 0; s < 4; s++) begin
            len = (s == 3) ? 256 : $urandom_range(0, 40);
            for (int p = 0; p < 256; p++)
                mem[s * 256 + p] = (p < len) ? 4'($urandom_range(0, 14)) : 4'hF;
        end
        loop_en = 0;
        do_reset();
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 2000 && !song_done; i++) step(0, 0, 0, 1);
        chk("maxptr_done", int'(song_done), 1);
        chk("maxptr_addr", int'(rom_addr), 10'h3FF);

        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 99) == 0) loop_en = ~loop_en;
            pl = ($urandom_range(0, 99) < 3);
            nx = ($urandom_range(0, 99) < 2);
            pv = ($urandom_range(0, 99) < 2);
            tk = ($urandom_range(0, 99) < 30);
            step(pl, nx, pv, tk);
        end
        @(negedge clk); @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
